// File: rtl/alu_tree_pipe.sv
// Pipelined binary tree of float ALU nodes: one register stage per tree level, elastic valid/ready flow.
// Define ALU_TREE_PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module alu_tree_pipe #(
  parameter int DEPTH = 3,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_vld,
  output logic                                      in_rdy,
  input  logic [(2**DEPTH)*(EXP_W+MAN_W+1)-1:0]     in_data,
  input  logic [(2**DEPTH-1)*2-1:0]                 in_mode,
  output logic                                      out_vld,
  input  logic                                      out_rdy,
  output logic [(2**DEPTH-1)*(EXP_W+MAN_W+1)-1:0]   out_nodes
`ifdef ALU_TREE_PIPE_STALL_CNT_EN
  ,
  output logic [31:0]                               stall_cnt
`endif
);

  localparam int W          = EXP_W + MAN_W + 1;
  localparam int N_ALU      = 2**DEPTH - 1;
  localparam int FIRST_LEAF = 2**(DEPTH-1) - 1;

  localparam logic [EXP_W:0]   EXP_INF_A = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W+1:0] EXP_INF_M = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EXP_W+1:0] BIAS_M    = {3'b000, {(EXP_W-1){1'b1}}};

  localparam logic [1:0] MODE_SUM   = 2'b00;
  localparam logic [1:0] MODE_PROD  = 2'b01;
  localparam logic [1:0] MODE_PASS0 = 2'b10;

  // Magnitude add, truncating; zero exponent is treated as zero, overflow saturates to infinity.
  function automatic logic [W-1:0] flt_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [EXP_W-1:0] ea, eb, eh, el, diff;
    logic [MAN_W:0]   mh, ml;
    logic [MAN_W+1:0] sum;
    logic [EXP_W:0]   er;
    logic [W-1:0]     r;
    ea = a[W-2 -: EXP_W];
    eb = b[W-2 -: EXP_W];
    if (ea >= eb) begin
      eh = ea; el = eb;
      mh = {1'b1, a[MAN_W-1:0]};
      ml = {1'b1, b[MAN_W-1:0]};
    end else begin
      eh = eb; el = ea;
      mh = {1'b1, b[MAN_W-1:0]};
      ml = {1'b1, a[MAN_W-1:0]};
    end
    if (el == '0) ml = '0;
    diff = eh - el;
    ml   = ml >> diff;
    sum  = {1'b0, mh} + {1'b0, ml};
    er   = {1'b0, eh};
    if (sum[MAN_W+1]) begin
      sum = sum >> 1;
      er  = er + {{EXP_W{1'b0}}, 1'b1};
    end
    if (eh == '0)
      r = '0;
    else if (er >= EXP_INF_A)
      r = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      r = {1'b0, er[EXP_W-1:0], sum[MAN_W-1:0]};
    return r;
  endfunction

  // Magnitude multiply, truncating; underflow flushes to zero, overflow saturates to infinity.
  function automatic logic [W-1:0] flt_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*MAN_W+1:0] ma, mb, p;
    logic [EXP_W+1:0]   e;
    logic [MAN_W-1:0]   frac;
    logic [W-1:0]       r;
    ma = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]};
    mb = {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
    p  = ma * mb;
    e  = {2'b00, a[W-2 -: EXP_W]} + {2'b00, b[W-2 -: EXP_W]}
         + {{(EXP_W+1){1'b0}}, p[2*MAN_W+1]};
    if (p[2*MAN_W+1])
      frac = p[2*MAN_W -: MAN_W];
    else
      frac = p[2*MAN_W-1 -: MAN_W];
    if (a[W-2 -: EXP_W] == '0 || b[W-2 -: EXP_W] == '0 || e <= BIAS_M)
      r = '0;
    else if (e - BIAS_M >= EXP_INF_M)
      r = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else begin
      e = e - BIAS_M;
      r = {1'b0, e[EXP_W-1:0], frac};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] alu(input logic [1:0] m, input logic [W-1:0] x0,
                                       input logic [W-1:0] x1);
    logic [W-1:0] r;
    case (m)
      MODE_SUM:   r = flt_add(x0, x1);
      MODE_PROD:  r = flt_mul(x0, x1);
      MODE_PASS0: r = x0;
      default:    r = x1;
    endcase
    return r;
  endfunction

  // Heap depth of node k (root is depth 0).
  function automatic int node_level(input int k);
    int d;
    d = 0;
    for (int j = 1; j < 7; j++)
      if (k + 1 >= (1 << j)) d = j;
    return d;
  endfunction

  // Stage s (0-based) computes heap depth DEPTH-1-s and carries deeper results forward,
  // so the last stage holds every node of one transaction.
  logic [W-1:0]     node_q [DEPTH][N_ALU];
  logic [W-1:0]     node_d [DEPTH][N_ALU];
  logic [1:0]       mode_q [DEPTH][N_ALU];
  logic [1:0]       mode_d [DEPTH][N_ALU];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] adv;

  always_comb begin
    int li, lvl;
    li  = 0;
    lvl = 0;
    for (int s = 0; s < DEPTH; s++)
      for (int k = 0; k < N_ALU; k++) begin
        node_d[s][k] = '0;
        mode_d[s][k] = MODE_SUM;
      end
    for (int k = 0; k < N_ALU; k++) begin
      mode_d[0][k] = in_mode[2*k +: 2];
      if (node_level(k) == DEPTH - 1) begin
        li = k - FIRST_LEAF;
        node_d[0][k] = alu(in_mode[2*k +: 2], in_data[2*li*W +: W], in_data[(2*li+1)*W +: W]);
      end
    end
    for (int s = 1; s < DEPTH; s++)
      for (int k = 0; k < N_ALU; k++) begin
        mode_d[s][k] = mode_q[s-1][k];
        lvl = node_level(k);
        if (lvl == DEPTH - 1 - s)
          node_d[s][k] = alu(mode_q[s-1][k], node_q[s-1][2*k+1], node_q[s-1][2*k+2]);
        else if (lvl > DEPTH - 1 - s)
          node_d[s][k] = node_q[s-1][k];
      end
  end

  // A stage advances unless it and every stage after it are full while the output is blocked.
  always_comb begin
    logic all_full;
    all_full = 1'b0;
    adv      = '0;
    for (int s = 0; s < DEPTH; s++) begin
      all_full = 1'b1;
      for (int j = s; j < DEPTH; j++)
        all_full = all_full & v_q[j];
      adv[s] = !all_full || out_rdy;
    end
  end

  assign in_rdy  = adv[0] && !rst;
  assign out_vld = v_q[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      if (adv[0]) v_q[0] <= in_vld && in_rdy;
      for (int s = 1; s < DEPTH; s++)
        if (adv[s]) v_q[s] <= v_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++)
      if (adv[s])
        for (int k = 0; k < N_ALU; k++) begin
          node_q[s][k] <= node_d[s][k];
          mode_q[s][k] <= mode_d[s][k];
        end
  end

  always_comb begin
    out_nodes = '0;
    for (int k = 0; k < N_ALU; k++)
      out_nodes[k*W +: W] = v_q[DEPTH-1] ? node_q[DEPTH-1][k] : '0;
  end

`ifdef ALU_TREE_PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (out_vld && !out_rdy && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
